// File: rtl/video_capture_if.sv
// Video-in / pixel-memory-out signal bundle for video_capture.
// The source drives it through master; the capture block uses slave.
interface video_capture_if;
  logic [23:0] In_pData;
  logic        In_pVSync;
  logic        In_pHSync;
  logic        In_pVDE;
  logic        Mem_Write;
  logic [18:0] Mem_Addr;
  logic [11:0] Mem_Data;

  modport master (
    output In_pData, In_pVSync, In_pHSync, In_pVDE,
    input  Mem_Write, Mem_Addr, Mem_Data
  );

  modport slave (
    input  In_pData, In_pVSync, In_pHSync, In_pVDE,
    output Mem_Write, Mem_Addr, Mem_Data
  );
endinterface

// File: rtl/video_capture.sv
// Frame grabber: RGB888 video in, RGB444 linear pixel writes out, one-cycle latency, no backpressure.
// Define VCAP_MEAS_EN to build the frame/line timing measurement counters; otherwise Meas_* read 0.
module video_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic                clk,
  input  logic                rstn,
  video_capture_if.slave      bus,
  input  logic                Capture_En,
  output logic                Frame_Done,
  output logic                Frame_Err,
  output logic                Overflow,
  output logic [31:0]         Meas_Frame_Clocks,
  output logic [15:0]         Meas_Line_Pixels,
  output logic [15:0]         Meas_Lines
);

  localparam int TOTAL = H_ACTIVE * V_ACTIVE;

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE} state_t;

  logic [23:0] pix_q;
  logic        vs_q, hs_q, vde_q;
  logic        vs_prev_q, vde_prev_q;
  state_t      state_q, state_d;
  logic [18:0] addr_q, addr_d;
  logic [19:0] pix_cnt_q, pix_cnt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;
  logic        mem_write;
  logic [11:0] mem_data;
  logic        fs;
  logic        unused_sig;

  assign fs = vs_prev_q & ~vs_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pix_q      <= '0;
      vs_q       <= 1'b1;
      hs_q       <= 1'b1;
      vde_q      <= 1'b0;
      vs_prev_q  <= 1'b1;
      vde_prev_q <= 1'b0;
      state_q    <= IDLE;
      addr_q     <= '0;
      pix_cnt_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      pix_q      <= bus.In_pData;
      vs_q       <= bus.In_pVSync;
      hs_q       <= bus.In_pHSync;
      vde_q      <= bus.In_pVDE;
      vs_prev_q  <= vs_q;
      vde_prev_q <= vde_q;
      state_q    <= state_d;
      addr_q     <= addr_d;
      pix_cnt_q  <= pix_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    pix_cnt_d = pix_cnt_q;
    done_d    = 1'b0;
    err_d     = err_q;
    ovf_d     = ovf_q;
    mem_write = 1'b0;
    mem_data  = '0;
    case (state_q)
      IDLE: begin
        if (Capture_En) begin
          state_d = ARM;
          ovf_d   = 1'b0;
        end
      end
      ARM: begin
        if (!Capture_En) begin
          state_d = IDLE;
        end else if (fs) begin
          state_d   = CAPTURE;
          addr_d    = '0;
          pix_cnt_d = '0;
        end
      end
      CAPTURE: begin
        mem_data = {pix_q[23:20], pix_q[15:12], pix_q[7:4]};
        if (fs) begin
          // Capture_En is only sampled here, so a dropped enable lets the frame finish.
          done_d    = 1'b1;
          err_d     = (pix_cnt_q != 20'(TOTAL));
          addr_d    = '0;
          pix_cnt_d = '0;
          if (!Capture_En) state_d = IDLE;
        end else if (vde_q) begin
          if (pix_cnt_q != '1) pix_cnt_d = pix_cnt_q + 20'd1;
          if (addr_q == 19'(TOTAL)) begin
            ovf_d = 1'b1;
          end else begin
            mem_write = 1'b1;
            addr_d    = addr_q + 19'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.Mem_Write = mem_write;
  assign bus.Mem_Addr  = addr_q;
  assign bus.Mem_Data  = mem_data;
  assign Frame_Done    = done_q;
  assign Frame_Err     = err_q;
  assign Overflow      = ovf_q;

`ifdef VCAP_MEAS_EN
  logic [31:0] fclk_cnt_q, fclk_cnt_d, meas_fclk_q, meas_fclk_d;
  logic [15:0] lpix_cnt_q, lpix_cnt_d, meas_lpix_q, meas_lpix_d;
  logic [15:0] lines_cnt_q, lines_cnt_d, meas_lines_q, meas_lines_d;
  logic        line_end, line_rise;

  assign line_end  = vde_prev_q & ~vde_q;
  assign line_rise = vde_q & ~vde_prev_q;

  always_comb begin
    fclk_cnt_d   = (fclk_cnt_q == '1) ? fclk_cnt_q : fclk_cnt_q + 32'd1;
    lpix_cnt_d   = '0;
    lines_cnt_d  = lines_cnt_q;
    meas_fclk_d  = meas_fclk_q;
    meas_lpix_d  = meas_lpix_q;
    meas_lines_d = meas_lines_q;
    if (vde_q) lpix_cnt_d = (lpix_cnt_q == '1) ? lpix_cnt_q : lpix_cnt_q + 16'd1;
    if (line_rise && lines_cnt_q != '1) lines_cnt_d = lines_cnt_q + 16'd1;
    if (line_end) meas_lpix_d = lpix_cnt_q;
    // The FS cycle itself is clock 1 of the new frame.
    if (fs) begin
      meas_fclk_d  = fclk_cnt_q;
      fclk_cnt_d   = 32'd1;
      meas_lines_d = lines_cnt_q;
      lines_cnt_d  = {15'd0, line_rise};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fclk_cnt_q   <= '0;
      lpix_cnt_q   <= '0;
      lines_cnt_q  <= '0;
      meas_fclk_q  <= '0;
      meas_lpix_q  <= '0;
      meas_lines_q <= '0;
    end else begin
      fclk_cnt_q   <= fclk_cnt_d;
      lpix_cnt_q   <= lpix_cnt_d;
      lines_cnt_q  <= lines_cnt_d;
      meas_fclk_q  <= meas_fclk_d;
      meas_lpix_q  <= meas_lpix_d;
      meas_lines_q <= meas_lines_d;
    end
  end

  assign Meas_Frame_Clocks = meas_fclk_q;
  assign Meas_Line_Pixels  = meas_lpix_q;
  assign Meas_Lines        = meas_lines_q;
`else
  assign Meas_Frame_Clocks = '0;
  assign Meas_Line_Pixels  = '0;
  assign Meas_Lines        = '0;
`endif

  // HSync and the low colour nibbles are registered but carry no decision.
  assign unused_sig = ^{hs_q, vde_prev_q, pix_q[19:16], pix_q[11:8], pix_q[3:0]};

endmodule

// File: tb/tb_video_capture.sv
// Directed bench for video_capture on a reduced 8x4 active raster (12 clk/line, n_act+3 lines/frame).
module tb_video_capture;
  localparam int H     = 8;
  localparam int V     = 4;
  localparam int H_TOT = 12;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        capture_en = 1'b0;
  logic        frame_done, frame_err, overflow;
  logic [31:0] meas_frame_clocks;
  logic [15:0] meas_line_pixels, meas_lines;

  video_capture_if vif ();

  video_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .bus               (vif),
    .Capture_En        (capture_en),
    .Frame_Done        (frame_done),
    .Frame_Err         (frame_err),
    .Overflow          (overflow),
    .Meas_Frame_Clocks (meas_frame_clocks),
    .Meas_Line_Pixels  (meas_line_pixels),
    .Meas_Lines        (meas_lines)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Observation counters, sampled on the falling edge.
  int  wr_total = 0, done_total = 0, data_bad = 0, seq_bad = 0;
  int  zero_wr = 0, dat_nowr = 0, prev_addr = -1, max_addr = -1;
  time t_wr0 = 0, t_vde0 = 0;

  always @(negedge clk) begin
    if (frame_done === 1'b1) done_total <= done_total + 1;
    if (vif.Mem_Write === 1'b1) begin
      wr_total <= wr_total + 1;
      if (vif.Mem_Data !== 12'hACF) data_bad <= data_bad + 1;
      if (vif.Mem_Addr == 19'd0) begin
        zero_wr <= zero_wr + 1;
        t_wr0   <= $time;
      end else if (int'(vif.Mem_Addr) != prev_addr + 1) begin
        seq_bad <= seq_bad + 1;
      end
      prev_addr <= int'(vif.Mem_Addr);
      if (int'(vif.Mem_Addr) > max_addr) max_addr <= int'(vif.Mem_Addr);
    end else if (vif.Mem_Data !== 12'h000) begin
      dat_nowr <= dat_nowr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame: line 0 VSync low, line 1 blank, n_act active lines, one blank line.
  task automatic drive_frame(input int n_act, input int drop_line, input int rst_line);
    logic act;
    for (int ln = 0; ln < n_act + 3; ln++) begin
      for (int c = 0; c < H_TOT; c++) begin
        tick();
        if (c == 0 && ln == rst_line) begin
          rstn = 1'b0;
          return;
        end
        if (c == 0 && ln == drop_line) capture_en = 1'b0;
        act = (ln >= 2 && ln < n_act + 2 && c < H);
        vif.In_pVSync = (ln != 0);
        vif.In_pHSync = !(c == 9 || c == 10);
        vif.In_pVDE   = act;
        vif.In_pData  = act ? 24'hA5C3F0 : 24'h000000;
        if (act && ln == 2 && c == 0) t_vde0 = $time;
      end
    end
  endtask

  int w0, d0, z0, n0;
  int exp_fclk, exp_lpix, exp_lines;

  initial begin
`ifdef VCAP_MEAS_EN
    exp_fclk = 84; exp_lpix = 8; exp_lines = 4;
`else
    exp_fclk = 0;  exp_lpix = 0; exp_lines = 0;
`endif
    vif.In_pData = '0; vif.In_pVSync = 1'b1; vif.In_pHSync = 1'b1; vif.In_pVDE = 1'b0;
    repeat (3) tick();
    check("rst_mem_write", vif.Mem_Write, 0);
    check("rst_mem_addr", vif.Mem_Addr, 0);
    check("rst_mem_data", vif.Mem_Data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overflow", overflow, 0);
    check("rst_meas_fclk", meas_frame_clocks, 0);
    check("rst_meas_lpix", meas_line_pixels, 0);
    check("rst_meas_lines", meas_lines, 0);

    rstn = 1'b1; capture_en = 1'b1;
    repeat (3) tick();

    // F1: ARM -> CAPTURE, no Frame_Done for the arming FS
    w0 = wr_total; d0 = done_total;
    drive_frame(4, -1, -1);
    check("f1_writes", wr_total - w0, 32);
    check("f1_no_done", done_total - d0, 0);
    check("f1_latency", 32'(t_wr0 - t_vde0), 14);
    check("f1_max_addr", max_addr, 31);

    // F2: ends F1 cleanly, measurement reflects F1
    w0 = wr_total; d0 = done_total;
    drive_frame(4, -1, -1);
    check("f2_writes", wr_total - w0, 32);
    check("f2_done", done_total - d0, 1);
    check("f2_err", frame_err, 0);
    check("f2_overflow", overflow, 0);
    check("meas_frame_clocks", meas_frame_clocks, exp_fclk);
    check("meas_line_pixels", meas_line_pixels, exp_lpix);
    check("meas_lines", meas_lines, exp_lines);
    check("data_rgb444", data_bad, 0);
    check("addr_sequence", seq_bad, 0);

    // F3: one extra active line overruns the buffer
    w0 = wr_total; d0 = done_total;
    drive_frame(5, -1, -1);
    check("f3_writes", wr_total - w0, 32);
    check("f3_done", done_total - d0, 1);
    check("f3_overflow", overflow, 1);
    check("f3_addr_hold", vif.Mem_Addr, 32);
    check("f3_max_addr", max_addr, 31);

    // F4: enable dropped mid-frame, frame still completes
    w0 = wr_total; d0 = done_total;
    drive_frame(4, 3, -1);
    check("f4_done", done_total - d0, 1);
    check("f4_err_of_f3", frame_err, 1);
    check("f4_writes", wr_total - w0, 32);
    check("f4_overflow_sticky", overflow, 1);

    // F5: F4 ends, FSM goes IDLE, nothing written
    w0 = wr_total; d0 = done_total; n0 = dat_nowr;
    drive_frame(4, -1, -1);
    check("f5_done", done_total - d0, 1);
    check("f5_err_of_f4", frame_err, 0);
    check("f5_no_writes", wr_total - w0, 0);
    check("f5_idle_data_zero", dat_nowr - n0, 0);
    check("f5_overflow_idle", overflow, 1);

    capture_en = 1'b1;
    repeat (3) tick();
    check("arm_clears_overflow", overflow, 0);

    // F6: reset asserted at the second active line
    d0 = done_total;
    drive_frame(4, -1, 3);
    #1;
    check("f6_no_done", done_total - d0, 0);
    check("arst_mem_write", vif.Mem_Write, 0);
    check("arst_mem_addr", vif.Mem_Addr, 0);
    check("arst_mem_data", vif.Mem_Data, 0);
    check("arst_frame_done", frame_done, 0);
    check("arst_meas_fclk", meas_frame_clocks, 0);
    check("arst_meas_lpix", meas_line_pixels, 0);
    repeat (3) tick();
    rstn = 1'b1;
    repeat (3) tick();

    // F7: first FS after reset gives no Frame_Done, capture restarts at 0
    w0 = wr_total; d0 = done_total; z0 = zero_wr;
    drive_frame(4, -1, -1);
    check("f7_no_done", done_total - d0, 0);
    check("f7_writes", wr_total - w0, 32);
    check("f7_restart_addr0", zero_wr - z0, 1);

    // F8: closes F7
    w0 = wr_total; d0 = done_total;
    drive_frame(0, -1, -1);
    check("f8_done", done_total - d0, 1);
    check("f8_err_of_f7", frame_err, 0);
    check("f8_no_writes", wr_total - w0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/video_capture.md
VIDEO_CAPTURE -- requirements
Module: video_capture

Interface
REQ-001 Parameter H_ACTIVE, default 640: expected active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480: expected active lines per frame.
REQ-003 Port clk, input, 1: pixel clock; the single clock for all logic.
REQ-004 Port rstn, input, 1: reset, asynchronous and active-low.
REQ-005 Port In_pData, input, 24: RGB888 pixel, R in [23:16], G in [15:8], B in [7:0].
REQ-006 Port In_pVSync, input, 1: vertical sync, active-low pulse.
REQ-007 Port In_pHSync, input, 1: horizontal sync, active-low pulse.
REQ-008 Port In_pVDE, input, 1: data-enable, high during active pixels.
REQ-009 Port Capture_En, input, 1: arms capture while high.
REQ-010 Port Mem_Write, output, 1: pixel write strobe.
REQ-011 Port Mem_Addr, output, 19: linear pixel address.
REQ-012 Port Mem_Data, output, 12: RGB444 pixel.
REQ-013 Port Frame_Done, output, 1: one-cycle pulse at the end of each captured frame.
REQ-014 Port Frame_Err, output, 1: last captured frame had a pixel count other than H_ACTIVE*V_ACTIVE.
REQ-015 Port Overflow, output, 1: sticky; a write was suppressed because the address limit was reached.
REQ-016 Port Meas_Frame_Clocks, output, 32: clocks between the last two frame starts.
REQ-017 Port Meas_Line_Pixels, output, 16: In_pVDE-high run length of the last completed line.
REQ-018 Port Meas_Lines, output, 16: In_pVDE rising edges counted in the last frame.

Function
REQ-019 All four video inputs SHALL be registered once; all decisions use the registered copies.
- REQ-020 Frame start (FS) SHALL be a registered In_pVSync 1->0 transition.
- REQ-021 Line end SHALL be a registered In_pVDE 1->0 transition.
REQ-022 The FSM SHALL have states IDLE, ARM and CAPTURE.
- REQ-023 IDLE->ARM when Capture_En=1.
- REQ-024 ARM->CAPTURE on FS; Mem_Addr SHALL clear to 0 on that transition.
- REQ-025 CAPTURE->CAPTURE on FS while Capture_En=1; Frame_Done pulses and Mem_Addr clears.
- REQ-026 CAPTURE->IDLE on FS while Capture_En=0; Frame_Done pulses.
- REQ-027 ARM->IDLE when Capture_En=0.
- REQ-028 Dropping Capture_En mid-frame SHALL NOT abort the frame; it completes at the next FS.
REQ-029 In CAPTURE, Mem_Write SHALL equal the registered VDE (one cycle of latency from the input pins).
- REQ-030 Mem_Data = {R[7:4], G[7:4], B[7:4]} of the same registered pixel.
- REQ-031 Mem_Addr SHALL hold during a write and increment by 1 on the cycle after each write.
REQ-032 Address limit: when Mem_Addr = H_ACTIVE*V_ACTIVE, Mem_Write SHALL be suppressed, Mem_Addr SHALL hold, and Overflow SHALL set.
- REQ-033 Overflow clears only on reset or an IDLE->ARM transition.
REQ-034 Frame_Err SHALL update with each Frame_Done: 1 if the pixels seen (including suppressed ones) != H_ACTIVE*V_ACTIVE.
REQ-035 Outside CAPTURE, Mem_Write SHALL be 0 and Mem_Data SHALL be 0.

Reset
REQ-036 On rstn low, all of the following SHALL clear immediately and asynchronously:
- state = IDLE;
- Mem_Write, Mem_Addr, Mem_Data, Frame_Done, Frame_Err, Overflow;
- all Meas_* outputs and internal counters;
- input registers (VSync and HSync registers to 1).
REQ-037 Reset mid-frame SHALL discard the frame; the first FS after release SHALL NOT pulse Frame_Done.

Configuration
REQ-038 Macro VCAP_MEAS_EN SHALL control the measurement block.
- REQ-039 Defined: Meas_* outputs update at each FS (Meas_Line_Pixels at each line end), independent of FSM state; counters saturate at all-ones.
- REQ-040 Undefined: measurement counters are not built; Meas_* outputs are tied to 0. Capture behaviour is unchanged.

Verification
REQ-041 800x525 timing, 640x480 active, HSync low 96 clk, VSync low 1600 clk, Capture_En=1, two frames -> exactly 307200 writes per frame, addresses 0..307199, one Frame_Done per frame, Frame_Err=0.
REQ-042 With VCAP_MEAS_EN, same stimulus -> Meas_Frame_Clocks=420000, Meas_Line_Pixels=640, Meas_Lines=480; without the macro -> all Meas_* read 0.
REQ-043 Pixel In_pData=24'hA5C3F0 driven with VDE -> Mem_Data=12'hACF with Mem_Write high exactly one cycle later.
REQ-044 Frame with 481 active lines -> Overflow=1, the last 640 pixels are not written, Mem_Addr holds at 307200, Frame_Err=1.
REQ-045 Capture_En dropped at line 100 -> frame completes, Frame_Done pulses, FSM returns to IDLE, and no writes occur in the next frame.
REQ-046 rstn asserted at line 200 -> all outputs 0 immediately; after release and Capture_En=1, the first FS produces no Frame_Done and capture restarts at address 0.
